// File: rtl/i960_bus_seq.sv
`default_nettype none
// ============================================================================
// Module      : i960_bus_seq
// Description : i960 local-bus cycle sequencer. Generates the internal PCLK
//               phase from clk2 and walks each access through SYNC/TI/TA/TD/TR.
//               Each access gets a per-region chip select, a write strobe and
//               processor READY. Region wait states come from parameter
//               nibbles. A region can instead complete on an external
//               acknowledge.
//               Optional feature macro: I960_BUS_TIMEOUT_EN (TD watchdog that
//               forces completion, pulses bus_err_o and latches err_region_o).
// Ports       : clk2_i        system clock (2x PCLK)
//               reset_i       synchronous active-high reset
//               as_n_i, blast_n_i, den_n_i, w_rn_i   processor bus strobes
//               addr_i        processor A[31:30]
//               ext_ack_n_i   per-region external acknowledge, active-low
//               pclk_o        internal PCLK phase
//               cs_n_o        per-region chip selects, active-low
//               we_n_o        write strobe, active-low
//               ready_n_o     processor READY, active-low
//               bus_err_o     one-clk2 pulse on timeout
//               err_region_o  region of the last timed-out access
// Revision    : 1.0 - initial release
// ============================================================================
module i960_bus_seq #(
    parameter int unsigned NREG           = 4,
    parameter logic [15:0] WAIT_VEC       = 16'h0000,
    parameter logic [15:0] BURST_WAIT_VEC = 16'h0000,
    parameter logic [3:0]  EXT_MASK       = 4'b0000,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic            clk2_i,
    input  logic            reset_i,
    input  logic            as_n_i,
    input  logic            blast_n_i,
    input  logic            den_n_i,
    input  logic            w_rn_i,
    input  logic [1:0]      addr_i,
    input  logic [NREG-1:0] ext_ack_n_i,
    output logic            pclk_o,
    output logic [NREG-1:0] cs_n_o,
    output logic            we_n_o,
    output logic            ready_n_o,
    output logic            bus_err_o,
    output logic [1:0]      err_region_o
);

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_TI   = 3'd1;
    localparam logic [2:0] S_TA   = 3'd2;
    localparam logic [2:0] S_TD   = 3'd3;
    localparam logic [2:0] S_TR   = 3'd4;

    generate
        if (NREG < 1 || NREG > 4 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
            $error("i960_bus_seq: NREG must be 1..4 and TIMEOUT 1..65535");
        end
    endgenerate

    logic [2:0] state_q, state_d;
    logic       pclk_q, pclk_d;
    logic [1:0] region_q, region_d;
    logic [3:0] wcnt_q, wcnt_d;

    logic [1:0] w_region_dec;
    logic [3:0] w_ack_n_pad;
    logic       w_done;
    logic       w_in_data;

    // Region index is A[31:30] folded onto the configured number of regions.
    assign w_region_dec = 2'({30'd0, addr_i} % NREG);

    // Pad the acknowledge vector to four bits so region_q can index it
    // directly; absent regions read as "not acknowledged".
    generate
        for (genvar g = 0; g < 4; g++) begin : g_ack_pad
            if (g < NREG) begin : g_used
                assign w_ack_n_pad[g] = ext_ack_n_i[g];
            end else begin : g_unused
                assign w_ack_n_pad[g] = 1'b1;
            end
        end
    endgenerate

    // Externally acknowledged regions ignore their counter; all others
    // finish when the counter has run down to zero.
    assign w_done = EXT_MASK[region_q] ? ~w_ack_n_pad[region_q]
                                       : (wcnt_q == 4'd0);

`ifdef I960_BUS_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] to_q, to_d;
    logic        bus_err_q, bus_err_d;
    logic [1:0]  err_region_q, err_region_d;
`endif

    always_comb begin
        state_d  = state_q;
        pclk_d   = ~pclk_q;
        region_d = region_q;
        wcnt_d   = wcnt_q;
`ifdef I960_BUS_TIMEOUT_EN
        // Held at zero outside TD, so it is already clear on TD entry.
        to_d         = 16'd0;
        bus_err_d    = 1'b0;
        err_region_d = err_region_q;
`endif
        case (state_q)
            S_SYNC: begin
                // Address strobe aligns the PCLK phase: PCLK restarts low.
                if (!as_n_i) begin
                    pclk_d   = 1'b0;
                    state_d  = S_TA;
                    region_d = w_region_dec;
                end
            end
            S_TI: begin
                if (pclk_q && !as_n_i) begin
                    state_d  = S_TA;
                    region_d = w_region_dec;
                end
            end
            S_TA: begin
                if (pclk_q) begin
                    state_d = S_TD;
                    wcnt_d  = WAIT_VEC[{region_q, 2'b00} +: 4];
                end
            end
            S_TD: begin
                if (pclk_q) begin
                    if (w_done) begin
                        state_d = S_TR;
                    end else if (wcnt_q != 4'd0) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end
`ifdef I960_BUS_TIMEOUT_EN
                to_d = to_q + 16'd1;
                // A normal completion on the same edge is not an error.
                if (to_q == TO_LAST && !(pclk_q && w_done)) begin
                    state_d      = S_TR;
                    bus_err_d    = 1'b1;
                    err_region_d = region_q;
                end
`endif
            end
            S_TR: begin
                if (pclk_q) begin
                    if (!blast_n_i) begin
                        state_d = S_TI;
                    end else begin
                        state_d = S_TD;
                        wcnt_d  = BURST_WAIT_VEC[{region_q, 2'b00} +: 4];
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk2_i) begin
        if (reset_i) begin
            state_q  <= S_SYNC;
            pclk_q   <= 1'b0;
            region_q <= 2'd0;
            wcnt_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            pclk_q   <= pclk_d;
            region_q <= region_d;
            wcnt_q   <= wcnt_d;
        end
    end

`ifdef I960_BUS_TIMEOUT_EN
    always_ff @(posedge clk2_i) begin
        if (reset_i) begin
            to_q         <= 16'd0;
            bus_err_q    <= 1'b0;
            err_region_q <= 2'd0;
        end else begin
            to_q         <= to_d;
            bus_err_q    <= bus_err_d;
            err_region_q <= err_region_d;
        end
    end

    assign bus_err_o    = bus_err_q;
    assign err_region_o = err_region_q;
`else
    assign bus_err_o    = 1'b0;
    assign err_region_o = 2'd0;
`endif

    // Active-low strobes are gated by reset so nothing can dip low while
    // reset is asserted, before the registers have been cleared.
    assign w_in_data = (state_q == S_TD) || (state_q == S_TR);
    assign pclk_o    = pclk_q;
    assign ready_n_o = ~(state_q == S_TR) | reset_i;
    assign we_n_o    = ~(w_in_data & w_rn_i & ~den_n_i & ~pclk_q & ~reset_i);

    generate
        for (genvar g = 0; g < NREG; g++) begin : g_cs
            assign cs_n_o[g] = ~(w_in_data & ~den_n_i & ~reset_i & (region_q == 2'(g)));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_i960_bus_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_i960_bus_seq
// Description : Directed bench for i960_bus_seq. Main instance: region waits
//               r0=3, r1=2 (burst 1), r2 external-ack, r3=0, TIMEOUT=20.
//               A second instance (NREG=2, all waits 0) shares the inputs and
//               covers zero-wait accesses and address folding.
//               Honours I960_BUS_TIMEOUT_EN for the external-ack access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i960_bus_seq;

    logic       clk2 = 1'b0;
    logic       reset, as_n, blast_n, den_n, w_rn;
    logic [1:0] addr;
    logic [3:0] ext_ack_n;

    logic       pclk, we_n, ready_n, bus_err;
    logic [3:0] cs_n;
    logic [1:0] err_region;
    logic       z_pclk, z_we_n, z_ready_n, z_bus_err;
    logic [1:0] z_cs_n, z_err_region;

    always #5 clk2 = ~clk2;

    i960_bus_seq #(
        .NREG           (4),
        .WAIT_VEC       (16'h0023),
        .BURST_WAIT_VEC (16'h0010),
        .EXT_MASK       (4'b0100),
        .TIMEOUT        (20)
    ) u_dut (
        .clk2_i       (clk2),
        .reset_i      (reset),
        .as_n_i       (as_n),
        .blast_n_i    (blast_n),
        .den_n_i      (den_n),
        .w_rn_i       (w_rn),
        .addr_i       (addr),
        .ext_ack_n_i  (ext_ack_n),
        .pclk_o       (pclk),
        .cs_n_o       (cs_n),
        .we_n_o       (we_n),
        .ready_n_o    (ready_n),
        .bus_err_o    (bus_err),
        .err_region_o (err_region)
    );

    i960_bus_seq #(
        .NREG           (2),
        .WAIT_VEC       (16'h0000),
        .BURST_WAIT_VEC (16'h0000),
        .EXT_MASK       (4'b0000),
        .TIMEOUT        (255)
    ) u_dut_z (
        .clk2_i       (clk2),
        .reset_i      (reset),
        .as_n_i       (as_n),
        .blast_n_i    (blast_n),
        .den_n_i      (den_n),
        .w_rn_i       (w_rn),
        .addr_i       (addr),
        .ext_ack_n_i  (ext_ack_n[1:0]),
        .pclk_o       (z_pclk),
        .cs_n_o       (z_cs_n),
        .we_n_o       (z_we_n),
        .ready_n_o    (z_ready_n),
        .bus_err_o    (z_bus_err),
        .err_region_o (z_err_region)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic       tr_ready [0:63];
    logic       tr_pclk  [0:63];
    logic       tr_we    [0:63];
    logic       tr_berr  [0:63];
    logic [3:0] tr_cs    [0:63];
    logic       tz_ready [0:63];
    logic [1:0] tz_cs    [0:63];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs n clk2 edges, recording outputs 1 ns after each edge. With start
    // set, as_n is held low across the first two edges (one PCLK period).
    task automatic run_trace(input int n, input bit start, input int blast_at);
        if (start) as_n = 1'b0;
        for (int i = 1; i <= n; i++) begin
            if (blast_at != 0 && i == blast_at) blast_n = 1'b0;
            @(posedge clk2);
            #1;
            tr_ready[i] = ready_n;
            tr_pclk[i]  = pclk;
            tr_we[i]    = we_n;
            tr_berr[i]  = bus_err;
            tr_cs[i]    = cs_n;
            tz_ready[i] = z_ready_n;
            tz_cs[i]    = z_cs_n;
            if (i == 2) as_n = 1'b1;
        end
    endtask

    function automatic int find_low(input int from, input int last);
        for (int i = from; i <= last; i++) begin
            if (tr_ready[i] == 1'b0) return i;
        end
        return 0;
    endfunction

    function automatic int count_low(input int last);
        int c = 0;
        for (int i = 1; i <= last; i++) begin
            if (tr_ready[i] == 1'b0) c++;
        end
        return c;
    endfunction

    function automatic int count_berr(input int last);
        int c = 0;
        for (int i = 1; i <= last; i++) begin
            if (tr_berr[i] == 1'b1) c++;
        end
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f1, f2, f3, f4;
        reset = 1'b1; as_n = 1'b1; blast_n = 1'b0; den_n = 1'b1; w_rn = 1'b0;
        addr = 2'd0; ext_ack_n = 4'hF;
        repeat (2) @(posedge clk2);
        #1;
        // Strobes active while reset is held: every output must stay idle.
        as_n = 1'b0; den_n = 1'b0; w_rn = 1'b1;
        @(posedge clk2);
        #1;
        check_eq("rst_pclk",    32'(pclk), 32'd0);
        check_eq("rst_ready",   32'(ready_n), 32'd1);
        check_eq("rst_cs",      32'(cs_n), 32'hF);
        check_eq("rst_we",      32'(we_n), 32'd1);
        check_eq("rst_berr",    32'(bus_err), 32'd0);
        check_eq("rst_errreg",  32'(err_region), 32'd0);
        check_eq("rst_z_cs",    32'(z_cs_n), 32'h3);
        as_n = 1'b1; reset = 1'b0;

        // Zero-wait single read from SYNC; addr 3 folds to region 1 at NREG=2.
        addr = 2'd3; den_n = 1'b0; w_rn = 1'b0; blast_n = 1'b0;
        run_trace(9, 1'b1, 0);
        check_eq("zw_first_ready", 32'(tr_ready[1]), 32'd1);
        check_eq("zw_first_cs",    32'(tr_cs[1]), 32'hF);
        check_eq("zw_pclk1",  32'(tr_pclk[1]), 32'd0);
        check_eq("zw_pclk2",  32'(tr_pclk[2]), 32'd1);
        check_eq("zw_pclk3",  32'(tr_pclk[3]), 32'd0);
        check_eq("zw_z_cs_td",  32'(tz_cs[3]), 32'h1);
        check_eq("zw_cs_td",    32'(tr_cs[3]), 32'h7);
        check_eq("zw_z_rdy4",   32'(tz_ready[4]), 32'd1);
        check_eq("zw_z_rdy5",   32'(tz_ready[5]), 32'd0);
        check_eq("zw_z_rdy6",   32'(tz_ready[6]), 32'd0);
        check_eq("zw_z_rdy7",   32'(tz_ready[7]), 32'd1);
        check_eq("zw_rdy5",     32'(tr_ready[5]), 32'd0);
        check_eq("zw_z_cs_ti",  32'(tz_cs[7]), 32'h3);

        // Region 0 read, 3 waits; ext_ack_n asserted must be ignored there.
        addr = 2'd0; ext_ack_n = 4'h0;
        run_trace(16, 1'b1, 0);
        check_eq("r0_fall",     32'(find_low(1, 16)), 32'd12);
        check_eq("r0_lowcnt",   32'(count_low(16)), 32'd2);
        check_eq("r0_cs",       32'(tr_cs[5]), 32'hE);
        check_eq("r0_we_read",  32'(tr_we[6]), 32'd1);
        check_eq("r0_cs_idle",  32'(tr_cs[15]), 32'hF);
        ext_ack_n = 4'hF;

        // Four-beat write burst to region 1: wait 2 then burst wait 1.
        addr = 2'd1; w_rn = 1'b1; blast_n = 1'b1;
        run_trace(32, 1'b1, 25);
        f1 = find_low(1, 32);
        f2 = find_low(f1 + 2, 32);
        f3 = find_low(f2 + 2, 32);
        f4 = find_low(f3 + 2, 32);
        check_eq("bu_beat1",   32'(f1), 32'd10);
        check_eq("bu_beat2",   32'(f2), 32'd16);
        check_eq("bu_beat3",   32'(f3), 32'd22);
        check_eq("bu_beat4",   32'(f4), 32'd28);
        check_eq("bu_lowcnt",  32'(count_low(32)), 32'd8);
        check_eq("bu_cs_ta",   32'(tr_cs[3]), 32'hF);
        check_eq("bu_cs_td",   32'(tr_cs[4]), 32'hD);
        check_eq("bu_we_lo",   32'(tr_we[4]), 32'd0);
        check_eq("bu_we_hi",   32'(tr_we[5]), 32'd1);
        check_eq("bu_cs_end",  32'(tr_cs[31]), 32'hF);
        check_eq("bu_we_end",  32'(tr_we[31]), 32'd1);

        // Region 2 completes on external acknowledge, held high here.
        blast_n = 1'b0; addr = 2'd2; w_rn = 1'b0; ext_ack_n = 4'hF;
        run_trace(40, 1'b1, 0);
`ifdef I960_BUS_TIMEOUT_EN
        check_eq("to_fall",    32'(find_low(1, 40)), 32'd24);
        check_eq("to_lowcnt",  32'(count_low(40)), 32'd2);
        check_eq("to_berrcnt", 32'(count_berr(40)), 32'd1);
        check_eq("to_berr24",  32'(tr_berr[24]), 32'd1);
        check_eq("to_errreg",  32'(err_region), 32'd2);
        check_eq("to_cs",      32'(tr_cs[24]), 32'hB);
`else
        check_eq("ext_nofall",   32'(count_low(40)), 32'd0);
        check_eq("ext_noberr",   32'(count_berr(40)), 32'd0);
        check_eq("ext_cs_wait",  32'(tr_cs[40]), 32'hB);
        ext_ack_n = 4'b1011;
        run_trace(6, 1'b0, 0);
        check_eq("ext_ack_fall", 32'(find_low(1, 6)), 32'd2);
        check_eq("ext_ack_low",  32'(count_low(6)), 32'd2);
        check_eq("ext_errreg",   32'(err_region), 32'd0);
`endif
        ext_ack_n = 4'hF;

        // Reset in the middle of a region 1 write data phase.
        addr = 2'd1; w_rn = 1'b1; den_n = 1'b0;
        run_trace(4, 1'b1, 0);
        check_eq("mr_we_td",  32'(tr_we[4]), 32'd0);
        check_eq("mr_cs_td",  32'(tr_cs[4]), 32'hD);
        reset = 1'b1;
        @(posedge clk2);
        #1;
        check_eq("mr_we",    32'(we_n), 32'd1);
        check_eq("mr_cs",    32'(cs_n), 32'hF);
        check_eq("mr_ready", 32'(ready_n), 32'd1);
        check_eq("mr_pclk",  32'(pclk), 32'd0);
        reset = 1'b0;
        // Back in SYNC: TA is entered on the very first edge.
        run_trace(12, 1'b1, 0);
        check_eq("mr_post_ready", 32'(tr_ready[1]), 32'd1);
        check_eq("mr_post_we",    32'(tr_we[1]), 32'd1);
        check_eq("mr_post_cs",    32'(tr_cs[1]), 32'hF);
        check_eq("mr_sync_fall",  32'(find_low(1, 12)), 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
